// File: rtl/alu_sched_pkg.sv
// Shared types for the ALU scheduler: FSM state encoding and opcode values.
package alu_sched_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ISSUE   = 2'd1,
    ST_CAPTURE = 2'd2,
    ST_RESP    = 2'd3
  } state_e;

  localparam logic OP_ADD = 1'b1;
  localparam logic OP_SUB = 1'b0;

endpackage

// File: rtl/alu_sched_rr_arbiter.sv
// Round-robin arbiter: picks the first active request after last_grant, wrapping around.
module rr_arbiter
  import alu_sched_pkg::*;
#(
  parameter int N  = 4,
  parameter int IW = 2
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] last_grant,
  output logic [N-1:0]  grant,
  output logic [IW-1:0] index
);

  logic          found_hi;
  logic          found_lo;
  logic [IW-1:0] idx_hi;
  logic [IW-1:0] idx_lo;

  // Lowest active index above last_grant wins; otherwise wrap to lowest active index overall.
  always_comb begin
    found_hi = 1'b0;
    found_lo = 1'b0;
    idx_hi   = '0;
    idx_lo   = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (req[i]) begin
        found_lo = 1'b1;
        idx_lo   = IW'(i);
        if (i > int'(last_grant)) begin
          found_hi = 1'b1;
          idx_hi   = IW'(i);
        end
      end
    end
  end

  assign index = found_hi ? idx_hi : idx_lo;

  generate
    for (genvar gi = 0; gi < N; gi++) begin : g_grant
      assign grant[gi] = found_lo && (index == IW'(gi));
    end
  endgenerate

endmodule

// File: rtl/alu_sched.sv
// Schedules requests from several ports onto one shared, externally instantiated ALU
// with a fixed IDLE -> ISSUE -> CAPTURE -> RESP sequence per operation.
module alu_sched
  import alu_sched_pkg::*;
#(
  parameter int DATA_WIDTH = 4,
  parameter int NUM_REQ    = 4,
  localparam int IDW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_REQ-1:0]            req_valid,
  output logic [NUM_REQ-1:0]            req_ready,
  input  logic [NUM_REQ-1:0]            req_op,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data1,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data2,
  output logic                          rsp_valid,
  input  logic                          rsp_ready,
  output logic [IDW-1:0]                rsp_id,
  output logic [DATA_WIDTH:0]           rsp_data,
  output logic                          alu_en,
  output logic                          alu_control,
  output logic [DATA_WIDTH-1:0]         alu_data1,
  output logic [DATA_WIDTH-1:0]         alu_data2,
  input  logic [DATA_WIDTH:0]           alu_y,
  output logic                          busy
);

  state_e                state_q, state_d;
  logic [NUM_REQ-1:0]    grant;
  logic [IDW-1:0]        win_idx;
  logic                  req_fire;

  logic [IDW-1:0]        last_grant_q, last_grant_d;
  logic [IDW-1:0]        idx_q, idx_d;
  logic                  op_q, op_d;
  logic [DATA_WIDTH-1:0] data1_q, data1_d;
  logic [DATA_WIDTH-1:0] data2_q, data2_d;
  logic [DATA_WIDTH:0]   rsp_data_q, rsp_data_d;
  logic [IDW-1:0]        rsp_id_q, rsp_id_d;

  logic [DATA_WIDTH-1:0] d1_arr [NUM_REQ];
  logic [DATA_WIDTH-1:0] d2_arr [NUM_REQ];

  generate
    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
      assign d1_arr[gi] = req_data1[gi*DATA_WIDTH +: DATA_WIDTH];
      assign d2_arr[gi] = req_data2[gi*DATA_WIDTH +: DATA_WIDTH];
    end
  endgenerate

  rr_arbiter #(
    .N  (NUM_REQ),
    .IW (IDW)
  ) u_arb (
    .req        (req_valid),
    .last_grant (last_grant_q),
    .grant      (grant),
    .index      (win_idx)
  );

  assign req_fire = (state_q == ST_IDLE) && (req_valid != '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:    if (req_fire) state_d = ST_ISSUE;
      ST_ISSUE:   state_d = ST_CAPTURE;
      ST_CAPTURE: state_d = ST_RESP;
      ST_RESP:    if (rsp_ready) state_d = ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase
  end

  // req_ready is also masked by rst so a reset cycle never looks like an accept.
  always_comb begin
    req_ready = '0;
    alu_en    = 1'b0;
    rsp_valid = 1'b0;
    busy      = 1'b1;
    case (state_q)
      ST_IDLE: begin
        busy = 1'b0;
        if (!rst) req_ready = grant;
      end
      ST_ISSUE: alu_en    = 1'b1;
      ST_RESP:  rsp_valid = 1'b1;
      default:  ;
    endcase
  end

  always_comb begin
    last_grant_d = last_grant_q;
    idx_d        = idx_q;
    op_d         = op_q;
    data1_d      = data1_q;
    data2_d      = data2_q;
    rsp_data_d   = rsp_data_q;
    rsp_id_d     = rsp_id_q;
    if (req_fire) begin
      last_grant_d = win_idx;
      idx_d        = win_idx;
      op_d         = req_op[win_idx];
      data1_d      = d1_arr[win_idx];
      data2_d      = d2_arr[win_idx];
    end
    if (state_q == ST_CAPTURE) begin
      rsp_data_d = alu_y;
      rsp_id_d   = idx_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      last_grant_q <= IDW'(NUM_REQ - 1);
      idx_q        <= '0;
      op_q         <= 1'b0;
      data1_q      <= '0;
      data2_q      <= '0;
      rsp_data_q   <= '0;
      rsp_id_q     <= '0;
    end else begin
      last_grant_q <= last_grant_d;
      idx_q        <= idx_d;
      op_q         <= op_d;
      data1_q      <= data1_d;
      data2_q      <= data2_d;
      rsp_data_q   <= rsp_data_d;
      rsp_id_q     <= rsp_id_d;
    end
  end

  assign alu_control = op_q;
  assign alu_data1   = data1_q;
  assign alu_data2   = data2_q;
  assign rsp_data    = rsp_data_q;
  assign rsp_id      = rsp_id_q;

endmodule

// File: doc/alu_sched.md
ALU_SCHED -- requirements
Module: alu_sched

Interface
REQ-001 Parameter DATA_WIDTH, default 4, SHALL set the operand width; results are DATA_WIDTH+1 bits.
REQ-002 Parameter NUM_REQ, default 4, SHALL set the number of requester ports (2..8).
REQ-003 clk  input  1  single clock; all state SHALL update on posedge clk.
REQ-004 rst  input  1  reset, synchronous and active-high.
REQ-005 req_valid  input  NUM_REQ  per-requester operation request.
REQ-006 req_ready  output  NUM_REQ  per-requester accept strobe, at most one bit high.
REQ-007 req_op  input  NUM_REQ  per-requester opcode: 1 = add, 0 = subtract.
REQ-008 req_data1  input  NUM_REQ*DATA_WIDTH  packed first operands, requester i in slice i.
REQ-009 req_data2  input  NUM_REQ*DATA_WIDTH  packed second operands, requester i in slice i.
REQ-010 rsp_valid  output  1  result available.
REQ-011 rsp_ready  input  1  result consumer accepts.
REQ-012 rsp_id  output  clog2(NUM_REQ)  index of the requester that owns rsp_data.
REQ-013 rsp_data  output  DATA_WIDTH+1  ALU result.
REQ-014 alu_en, alu_control  output  1 each  enable and opcode to the shared ALU.
REQ-015 alu_data1, alu_data2  output  DATA_WIDTH each  operands to the shared ALU.
REQ-016 alu_y  input  DATA_WIDTH+1  shared ALU registered result, valid one cycle after alu_en.
REQ-017 busy  output  1  high in every state except IDLE.

Function
REQ-018 FSM SHALL have the states IDLE, ISSUE, CAPTURE and RESP.
REQ-019 IDLE: if any req_valid is high, the block SHALL assert req_ready[winner] combinationally, latch the winner's op, operands and index, and go to ISSUE; otherwise it stays in IDLE.
REQ-020 Arbitration SHALL be round-robin: search starts at last_grant+1 modulo NUM_REQ; last_grant updates only on a grant.
REQ-021 ISSUE: alu_en=1 for exactly one cycle, with alu_control and alu_data1/2 driven from the latched values; next state is CAPTURE.
REQ-022 CAPTURE: rsp_data<=alu_y and rsp_id<=latched index; next state is RESP.
REQ-023 RESP: rsp_valid=1, with rsp_data and rsp_id stable; on rsp_valid&&rsp_ready the FSM goes to IDLE, otherwise it holds.
REQ-024 Latency SHALL be exactly 3 cycles: rsp_valid rises 3 cycles after the req_ready cycle; minimum issue interval is 4 cycles.
REQ-025 req_ready SHALL be 0 outside IDLE; a request is sampled only in IDLE.
REQ-026 alu_en SHALL be 0 outside ISSUE; alu_data1/2 and alu_control hold their latched values when alu_en is 0.
REQ-027 Results SHALL be passed through unmodified; a subtract underflow appears as a DATA_WIDTH+1-bit two's-complement wrap (e.g., 3-5 gives 5'b11110).
REQ-028 A requester that drops req_valid before its grant SHALL simply not be granted; no state is kept for it.

Reset
REQ-029 While rst=1 at posedge: state=IDLE, last_grant=NUM_REQ-1 (so requester 0 has first priority), rsp_valid=0, rsp_data=0, rsp_id=0, alu_en=0, alu_data1/2=0, alu_control=0, req_ready=0, busy=0.
REQ-030 Reset asserted mid-operation SHALL discard the in-flight operation with no response; the requester must re-request.

Structure
REQ-031 Package alu_sched_pkg SHALL hold the state enum and the opcode constants OP_ADD=1 and OP_SUB=0.
REQ-032 Round-robin selection SHALL be the sub-module rr_arbiter (inputs req and last_grant; outputs one-hot grant and index).
REQ-033 The ALU itself SHALL be instantiated outside alu_sched; its reset is wired at the parent level.

Verification (DATA_WIDTH=4, NUM_REQ=4)
REQ-034 Requester 0 sends add 9+8 with rsp_ready=1 -> rsp_valid 3 cycles later, rsp_id=0, rsp_data=5'd17.
REQ-035 Requester 2 sends subtract 3-5 -> rsp_data=5'b11110, rsp_id=2.
REQ-036 All four req_valid high from reset, rsp_ready=1 -> grant order 0,1,2,3; then requesters 0 and 3 request -> order 0,3.
REQ-037 rsp_ready held 0 for 5 cycles while in RESP -> rsp_valid, rsp_data and rsp_id stay stable, all req_ready stay 0, alu_en stays 0.
REQ-038 rst pulsed during CAPTURE -> next cycle state=IDLE and rsp_valid=0; the still-valid request is re-granted with requester 0 at first priority.
